// File: rtl/etcpu_inst_loader.sv
// etcpu_inst_loader: length-prefixed little-endian byte-stream loader that packs
// bytes into 32-bit words, writes them to instruction memory at consecutive
// word addresses and releases the CPU from reset after a complete load.
// Optional: define ETCPU_LOADER_CSUM_EN to require a trailing XOR checksum byte.
module etcpu_inst_loader #(
  parameter int unsigned INST_MEM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_vld,
  input  logic [7:0]  in_dat,
  output logic        in_rdy,
  output logic        inst_mem_wr_wen,
  output logic [31:0] inst_mem_wr_addr,
  output logic [31:0] inst_mem_wr_dat,
  output logic        cpu_rst_n,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_WRITE, S_DONE, S_ERR
`ifdef ETCPU_LOADER_CSUM_EN
    , S_CSUM
`endif
  } state_t;

  // State entered once the last word (or an empty program) has been handled.
`ifdef ETCPU_LOADER_CSUM_EN
  localparam state_t S_FIN = S_CSUM;
`else
  localparam state_t S_FIN = S_DONE;
`endif

  localparam logic [16:0] DEPTH = 17'(INST_MEM_DEPTH);

  state_t      state, state_nxt;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [15:0] word_idx;
  logic [1:0]  byte_idx;
  logic [31:0] word;
  logic [15:0] len_full;
  logic        fire;
  logic        can_start;
`ifdef ETCPU_LOADER_CSUM_EN
  logic [7:0]  csum;
`endif

  assign len_full  = {in_dat, len_lo};
  assign fire      = in_vld & in_rdy;
  assign can_start = start & ((state == S_IDLE) | (state == S_DONE) | (state == S_ERR));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (start) state_nxt = S_LEN0;
      S_LEN0: if (fire) state_nxt = S_LEN1;
      S_LEN1: begin
        if (fire) begin
          if ({1'b0, len_full} > DEPTH) state_nxt = S_ERR;
          else if (len_full == '0)      state_nxt = S_FIN;
          else                          state_nxt = S_DATA;
        end
      end
      S_DATA:  if (fire && byte_idx == 2'd3) state_nxt = S_WRITE;
      S_WRITE: state_nxt = (word_idx + 16'd1 == len) ? S_FIN : S_DATA;
`ifdef ETCPU_LOADER_CSUM_EN
      S_CSUM:  if (fire) state_nxt = (in_dat == csum) ? S_DONE : S_ERR;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // Length capture, word assembly, word index and running checksum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_lo   <= '0;
      len      <= '0;
      word_idx <= '0;
      byte_idx <= '0;
      word     <= '0;
`ifdef ETCPU_LOADER_CSUM_EN
      csum     <= '0;
`endif
    end else begin
      if (can_start) begin
        word_idx <= '0;
        byte_idx <= '0;
`ifdef ETCPU_LOADER_CSUM_EN
        csum     <= '0;
`endif
      end
`ifdef ETCPU_LOADER_CSUM_EN
      if (fire && (state == S_LEN0 || state == S_LEN1 || state == S_DATA))
        csum <= csum ^ in_dat;
`endif
      case (state)
        S_LEN0:  if (fire) len_lo <= in_dat;
        S_LEN1:  if (fire) len <= len_full;
        S_DATA: begin
          if (fire) begin
            word[{byte_idx, 3'b000} +: 8] <= in_dat;
            byte_idx <= byte_idx + 2'd1;
          end
        end
        S_WRITE: word_idx <= word_idx + 16'd1;
        default: ;
      endcase
    end
  end

  // Outputs decoded directly from registered state.
  always_comb begin
    in_rdy = (state == S_LEN0) | (state == S_LEN1) | (state == S_DATA);
`ifdef ETCPU_LOADER_CSUM_EN
    in_rdy = in_rdy | (state == S_CSUM);
`endif
    busy             = in_rdy | (state == S_WRITE);
    inst_mem_wr_wen  = (state == S_WRITE);
    inst_mem_wr_addr = inst_mem_wr_wen ? {14'b0, word_idx, 2'b00} : '0;
    inst_mem_wr_dat  = inst_mem_wr_wen ? word : '0;
    done             = (state == S_DONE);
    err              = (state == S_ERR);
    cpu_rst_n        = (state == S_DONE);
  end

endmodule

// File: doc/etcpu_inst_loader.md
# etcpu_inst_loader

Byte-stream program loader that fills the instruction memory of the CPU environment before execution. It sits in front of the instruction-memory write port (`inst_mem_wr_wen`/`inst_mem_wr_addr`/`inst_mem_wr_dat`) and drives the CPU reset (`rst_n_cpu`). It accepts a length-prefixed little-endian byte stream over a valid/ready handshake and packs it into 32-bit words. Each word is written at consecutive word-aligned addresses, and the CPU is released from reset only after a complete, valid load.

## Interface
- `INST_MEM_DEPTH`, 1024, instruction memory depth in 32-bit words; word counts above this are rejected.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous reset, active-high.
- `start`  in  1  single-cycle pulse; begins a load. Ignored unless state is IDLE, DONE or ERR.
- `in_vld`  in  1  input byte valid.
- `in_dat`  in  8  input byte.
- `in_rdy`  out  1  loader accepts a byte this cycle; a byte transfers when `in_vld & in_rdy`.
- `inst_mem_wr_wen`  out  1  instruction memory write enable, one-cycle pulse per word.
- `inst_mem_wr_addr`  out  32  byte address, word-aligned (bits [1:0] = 0).
- `inst_mem_wr_dat`  out  32  write data.
- `cpu_rst_n`  out  1  active-low CPU reset; drives `rst_n_cpu`.
- `busy`  out  1  load in progress (states LEN0..WRITE, CSUM).
- `done`  out  1  last load completed successfully (level).
- `err`  out  1  last load failed (level, sticky until next `start`).

## Operation
- Reset values:
  - All outputs are 0, including `cpu_rst_n` (CPU held in reset).
  - State is IDLE; internal counters are 0.
- States: IDLE, LEN0, LEN1, DATA, WRITE, CSUM (macro only), DONE, ERR.
- IDLE/DONE/ERR + `start`:
  - Go to LEN0, clear `done`/`err`, drive `cpu_rst_n`=0.
  - Clear the word index, byte index and checksum.
- LEN0: accept byte, giving `len[7:0]`; go to LEN1.
- LEN1: accept byte, giving `len[15:8]`. Then:
  - `len` > `INST_MEM_DEPTH`: go to ERR.
  - `len` == 0: go to CSUM (macro) or DONE.
  - Otherwise: go to DATA.
- DATA: accept bytes little-endian.
  - Byte k of a word goes to bits [8k+7:8k].
  - After byte 3, go to WRITE.
- WRITE: one cycle, `in_rdy`=0.
  - `inst_mem_wr_wen`=1, `inst_mem_wr_addr` = word_idx×4, `inst_mem_wr_dat` = assembled word.
  - Then word_idx increments.
  - If word_idx+1 == `len`: go to CSUM (macro) or DONE; else go to DATA.
- DONE: `done`=1, `cpu_rst_n`=1. Stays until `start`.
- ERR: `err`=1, `cpu_rst_n`=0. Stays until `start`.
- `in_rdy` is 1 exactly in LEN0, LEN1, DATA and CSUM.
- `inst_mem_wr_*` are 0 outside WRITE.
- word_idx is 16 bits; address = {14'b0, word_idx, 2'b00}. No wrap: a length check precedes any write.
- `start` during a load is ignored; the load continues.
- `rst` mid-load: immediate return to IDLE, CPU held in reset; partially written memory is not cleared.
- A stalled source (`in_vld`=0) holds state indefinitely; there is no timeout.

## Timing
- Byte accepted at edge N is registered by edge N.
- 4th data byte accepted at edge N: `inst_mem_wr_wen` is high during cycle N+1; `in_rdy` returns at N+2.
- Peak throughput: 1 word per 5 cycles.
- Final WRITE cycle at edge M: `done`/`cpu_rst_n` go high after edge M+1 (registered, glitch-free).
- All outputs are registered or decoded directly from registered state.

## Configuration
- `ETCPU_LOADER_CSUM_EN` defined:
  - After the last word (or after LEN1 when `len`=0), state CSUM accepts one byte.
  - The running checksum is the XOR of every byte accepted from LEN0 through the last data byte.
  - Received byte == running XOR: go to DONE; otherwise go to ERR.
  - Words already written remain in memory; the CPU stays in reset on ERR.
- Not defined: no CSUM state, no checksum register; the stream ends after the last data byte.

## Test plan
- Reset, then `start` with stream 02 00 | 13 00 00 00 | 6F 00 00 00:
  - Two write pulses: addr 0x0 dat 0x00000013, then addr 0x4 dat 0x0000006F.
  - `done`=1 and `cpu_rst_n`=1 one cycle after the 2nd write.
  - With the macro, append checksum byte 0x7E.
- Length 0x0401 with depth 1024: `err`=1 after LEN1, no write pulses, `cpu_rst_n`=0.
- `in_vld` toggled randomly at 30% duty for 16 words: written words and addresses are identical to the back-to-back run; `in_rdy`=0 in every WRITE cycle.
- `rst` asserted after word 1 of 4: outputs return to reset values immediately. A fresh `start` plus a full stream completes with `done`=1.
- (macro) Checksum byte wrong by 1 bit: `err`=1, `done`=0, `cpu_rst_n`=0. A following `start` clears `err`.
- `start` pulsed mid-DATA: ignored, load completes normally; after DONE, `start` drops `cpu_rst_n` the next cycle.
